i2c_read_responder: RTL
=======================

// Module: i2c_read_responder
// PURPOSE
//  Slave-side read path of the I2C register interface; the transmit counterpart of the write-path controller.
//  Tracks the register pointer set by write transactions (address byte, then pointer byte).
//  On an address match with R/W=1, reads the register file and hands bytes to the byte-level I2C engine.
//  Auto-increments the pointer per byte; ends on master NACK, STOP or repeated START.
// PARAMETERS
//  DEVICE_ADDR  7'h40  7-bit target address, I2C_ADDR_WIDTH wide
//  REG_COUNT    256    number of registers; pointer wraps REG_COUNT-1 -> 0
//  RD_TIMEOUT   15     max cycles waiting for rd_valid before error fill (1..255)
// PORTS
//  clk          in   1               system clock
//  reset        in   1               asynchronous, active-high reset
//  sleep        in   1               sleep mode: read transactions not served
//  start        in   1               START / repeated START detected (pulse)
//  stop         in   1               STOP detected (pulse)
//  rx_valid     in   1               received byte strobe
//  rx_data      in   I2C_DATA_WIDTH  received byte
//  tx_ready     in   1               engine accepts tx_data this cycle
//  tx_data      out  I2C_DATA_WIDTH  byte to shift out
//  tx_valid     out  1               tx_data valid; held until tx_ready
//  mack_valid   in   1               master ACK bit sampled (pulse)
//  mack_nack    in   1               1 = master NACK; qualified by mack_valid
//  rd_en        out  1               register read request (1-cycle pulse)
//  rd_addr      out  REG_ADDR_WIDTH  register read address
//  rd_valid     in   1               rd_data valid (any latency >= 1 cycle)
//  rd_data      in   I2C_DATA_WIDTH  register read data
//  busy         out  1               high in any state other than IDLE
//  rd_timeout   out  1               1-cycle pulse when RD_TIMEOUT expires
// BEHAVIOUR
//  Reset: every output is 0; reg_ptr=0; state=IDLE; timeout counter=0. Reset mid-transfer aborts immediately.
//  States: IDLE, ADDR, PTR, WAIT_RD, PRESENT, WAIT_ACK. All outputs are registered.
//  start (any state): go to ADDR; clear tx_valid. start has priority over stop and over every other event in the same cycle.
//  stop (any state except when start is also high): go to IDLE; clear tx_valid. reg_ptr is kept.
//  ADDR, on rx_valid:
//   - rx_data[7:1] != DEVICE_ADDR -> IDLE.
//   - Match with rx_data[0]=0 -> PTR.
//   - Match with rx_data[0]=1 and sleep=1 -> IDLE; tx_valid stays 0.
//   - Match with rx_data[0]=1 and sleep=0 -> rd_en=1 and rd_addr=reg_ptr in the next cycle; go to WAIT_RD.
//  PTR, on rx_valid: reg_ptr <= rx_data[REG_ADDR_WIDTH-1:0]; go to IDLE. Data bytes of writes do not move reg_ptr.
//  WAIT_RD:
//   - Counter increments each cycle.
//   - rd_valid -> tx_data <= rd_data and tx_valid=1 in the next cycle; go to PRESENT. Latency is rd_valid to tx_valid = 1 cycle.
//   - Counter reaches RD_TIMEOUT without rd_valid -> tx_data=8'hFF, tx_valid=1, rd_timeout pulse; go to PRESENT.
//   - rd_valid in the same cycle as expiry: real data wins; no rd_timeout pulse.
//  PRESENT, on tx_valid && tx_ready:
//   - tx_valid=0 next cycle.
//   - reg_ptr <= (reg_ptr==REG_COUNT-1) ? 0 : reg_ptr+1.
//   - Go to WAIT_ACK.
//  WAIT_ACK, on mack_valid:
//   - nack=1 -> IDLE.
//   - nack=0 -> issue rd_en at the updated reg_ptr; go to WAIT_RD.
//  sleep asserted mid-read does not abort; it only gates entry at ADDR.
//  rd_en never asserts while a read is outstanding; at most 1 read is in flight.
//  rx_valid is ignored in WAIT_RD, PRESENT and WAIT_ACK.
//  mack_valid is ignored outside WAIT_ACK. tx_ready is ignored when tx_valid=0.
// STRUCTURE
//  i2c_pkg additions:
//   - typedef enum rsp_state_t {RSP_IDLE, RSP_ADDR, RSP_PTR, RSP_WAIT_RD, RSP_PRESENT, RSP_WAIT_ACK}.
//   - localparam I2C_RD_FILL = 8'hFF.
//  Reuse I2C_ADDR_WIDTH, I2C_DATA_WIDTH and REG_ADDR_WIDTH from i2c_pkg.
//  Single module, no sub-modules; the timeout counter is inline.
// TESTING
//  1. Write 0x80,0x05, then Sr, 0x81; regfile returns 0x3C at 2-cycle latency.
//     -> rd_addr=0x05, tx_data=0x3C; master NACK -> IDLE; reg_ptr=0x06.
//  2. Read 0x81 from ptr 0x10 with three ACKs then NACK.
//     -> rd_addr sequence 0x10,0x11,0x12,0x13; four tx bytes; busy falls after NACK.
//  3. Set ptr=0xFF (REG_COUNT=256), read 2 bytes with ACK.
//     -> rd_addr 0xFF then 0x00 (wrap).
//  4. Address 0x83 (mismatch) or 0x81 with sleep=1.
//     -> no rd_en, tx_valid stays 0, state returns to IDLE.
//  5. rd_valid withheld for 20 cycles, RD_TIMEOUT=15.
//     -> one rd_timeout pulse, tx_data=0xFF; late rd_valid does not change it.
//  6. stop during PRESENT, start+stop in same cycle, reset mid-WAIT_RD.
//     -> tx_valid cleared; start wins (ADDR); all outputs 0 and reg_ptr=0 after reset.

Source files
------------

// File: rtl/i2c_read_responder_pkg.sv
// Shared widths, fill byte and responder state encoding for the I2C register read path.
package i2c_read_responder_pkg;

  localparam int unsigned I2C_ADDR_WIDTH = 7;
  localparam int unsigned I2C_DATA_WIDTH = 8;
  localparam int unsigned REG_ADDR_WIDTH = 8;

  // Byte presented to the master when the register file never answers.
  localparam logic [I2C_DATA_WIDTH-1:0] I2C_RD_FILL = 8'hFF;

  typedef enum logic [2:0] {
    RSP_IDLE,
    RSP_ADDR,
    RSP_PTR,
    RSP_WAIT_RD,
    RSP_PRESENT,
    RSP_WAIT_ACK
  } rsp_state_t;

  function automatic logic [REG_ADDR_WIDTH-1:0] next_reg_ptr(
    input logic [REG_ADDR_WIDTH-1:0] ptr,
    input int unsigned               count
  );
    return (32'(ptr) == count - 1) ? '0 : ptr + 1'b1;
  endfunction

endpackage

// File: rtl/i2c_read_responder_if.sv
// Byte-engine and register-file handshake bundle seen by the I2C read responder.
interface i2c_read_responder_if;
  import i2c_read_responder_pkg::*;

  // Byte-level engine side
  logic                       start;
  logic                       stop;
  logic                       rx_valid;
  logic [I2C_DATA_WIDTH-1:0]  rx_data;
  logic                       tx_ready;
  logic [I2C_DATA_WIDTH-1:0]  tx_data;
  logic                       tx_valid;
  logic                       mack_valid;
  logic                       mack_nack;

  // Register file side
  logic                       rd_en;
  logic [REG_ADDR_WIDTH-1:0]  rd_addr;
  logic                       rd_valid;
  logic [I2C_DATA_WIDTH-1:0]  rd_data;

  modport slave (
    input  start, stop, rx_valid, rx_data, tx_ready, mack_valid, mack_nack, rd_valid, rd_data,
    output tx_data, tx_valid, rd_en, rd_addr
  );

  modport master (
    output start, stop, rx_valid, rx_data, tx_ready, mack_valid, mack_nack, rd_valid, rd_data,
    input  tx_data, tx_valid, rd_en, rd_addr
  );

endinterface

// File: rtl/i2c_read_responder.sv
// Slave-side I2C read path: tracks the register pointer from writes and streams register
// bytes to the byte engine, auto-incrementing until master NACK, STOP or repeated START.
module i2c_read_responder
  import i2c_read_responder_pkg::*;
#(
  parameter logic [I2C_ADDR_WIDTH-1:0] DEVICE_ADDR = 7'h40,
  parameter int unsigned               REG_COUNT   = 256,
  parameter int unsigned               RD_TIMEOUT  = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sleep,
  output logic                 busy,
  output logic                 rd_timeout,
  i2c_read_responder_if.slave  bus
);

  localparam logic [7:0] TimeoutLast = 8'(RD_TIMEOUT - 1);

  rsp_state_t                state_q, state_d;
  logic [REG_ADDR_WIDTH-1:0] reg_ptr_q, reg_ptr_d;
  logic [I2C_DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                      tx_valid_q, tx_valid_d;
  logic                      rd_en_q, rd_en_d;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]                cnt_q, cnt_d;
  logic                      busy_q, busy_d;
  logic                      timeout_q, timeout_d;

  logic addr_match;
  assign addr_match = (bus.rx_data[I2C_DATA_WIDTH-1:1] == DEVICE_ADDR);

  always_comb begin
    state_d    = state_q;
    reg_ptr_d  = reg_ptr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;

    // START outranks STOP, which outranks everything the current state would do.
    if (bus.start) begin
      state_d    = RSP_ADDR;
      tx_valid_d = 1'b0;
      cnt_d      = '0;
    end else if (bus.stop) begin
      state_d    = RSP_IDLE;
      tx_valid_d = 1'b0;
      cnt_d      = '0;
    end else begin
      unique case (state_q)
        RSP_IDLE: ;

        RSP_ADDR: begin
          if (bus.rx_valid) begin
            if (!addr_match) begin
              state_d = RSP_IDLE;
            end else if (!bus.rx_data[0]) begin
              state_d = RSP_PTR;
            end else if (sleep) begin
              state_d = RSP_IDLE;
            end else begin
              rd_en_d   = 1'b1;
              rd_addr_d = reg_ptr_q;
              cnt_d     = '0;
              state_d   = RSP_WAIT_RD;
            end
          end
        end

        RSP_PTR: begin
          if (bus.rx_valid) begin
            reg_ptr_d = bus.rx_data[REG_ADDR_WIDTH-1:0];
            state_d   = RSP_IDLE;
          end
        end

        RSP_WAIT_RD: begin
          // Real data arriving on the expiry cycle still wins over the fill byte.
          if (bus.rd_valid) begin
            tx_data_d  = bus.rd_data;
            tx_valid_d = 1'b1;
            cnt_d      = '0;
            state_d    = RSP_PRESENT;
          end else if (cnt_q == TimeoutLast) begin
            tx_data_d  = I2C_RD_FILL;
            tx_valid_d = 1'b1;
            timeout_d  = 1'b1;
            cnt_d      = '0;
            state_d    = RSP_PRESENT;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end

        RSP_PRESENT: begin
          if (tx_valid_q && bus.tx_ready) begin
            tx_valid_d = 1'b0;
            reg_ptr_d  = next_reg_ptr(reg_ptr_q, REG_COUNT);
            state_d    = RSP_WAIT_ACK;
          end
        end

        RSP_WAIT_ACK: begin
          if (bus.mack_valid) begin
            if (bus.mack_nack) begin
              state_d = RSP_IDLE;
            end else begin
              rd_en_d   = 1'b1;
              rd_addr_d = reg_ptr_q;
              cnt_d     = '0;
              state_d   = RSP_WAIT_RD;
            end
          end
        end

        default: state_d = RSP_IDLE;
      endcase
    end

    busy_d = (state_d != RSP_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RSP_IDLE;
      reg_ptr_q  <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      reg_ptr_q  <= reg_ptr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.rd_en    = rd_en_q;
  assign bus.rd_addr  = rd_addr_q;
  assign busy         = busy_q;
  assign rd_timeout   = timeout_q;

endmodule
